servo_pwm: RTL

SERVO_PWM -- requirements
Module: servo_pwm

---
 rtl/servo_pkg.sv | 20 ++
 rtl/pwm_frame.sv | 44 ++++
 rtl/servo_pwm.sv | 127 ++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Purpose: shared state encoding and default timing constants for the servo gate driver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package servo_pkg;

    // Gate positions and the two ramps between them
    typedef enum logic [1:0] {
        CERRADA  = 2'd0,
        ABRIENDO = 2'd1,
        ABIERTA  = 2'd2,
        CERRANDO = 2'd3
    } servo_state_t;

    // Defaults assume a 50 MHz clk_in: 20 ms frame, 1 ms closed, 2 ms open
    localparam int unsigned FRAME_CYC_DEF = 1000000;
    localparam int unsigned PW_CLOSED_DEF = 50000;
    localparam int unsigned PW_OPEN_DEF   = 100000;
    localparam int unsigned PW_STEP_DEF   = 5000;

endpackage

// File: rtl/pwm_frame.sv
// Purpose: free-running PWM frame counter, frame-boundary strobe and pulse comparator.
// Latency: pwm_out is registered, one cycle behind the frame_cnt < pw_cur compare.
// Backpressure: none; free-running, pw_cur is sampled every cycle.
module pwm_frame
    import servo_pkg::*;
#(
    parameter  int unsigned FRAME_CYC = FRAME_CYC_DEF,
    localparam int unsigned W         = $clog2(FRAME_CYC)
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic [W-1:0] pw_cur,
    output logic         frame_end,
    output logic         pwm_out
);

    localparam logic [W-1:0] LAST_CNT = W'(FRAME_CYC - 1);

    logic [W-1:0] frame_cnt;

    // Last cycle of the frame; the owner of pw_cur updates it on this edge
    assign frame_end = (frame_cnt == LAST_CNT);

    // Frame counter: 0..FRAME_CYC-1, then wrap
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + W'(1);
        end
    end

    // Registered comparator gives exactly pw_cur high cycles per frame
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (frame_cnt < pw_cur);
        end
    end

endmodule

// File: rtl/servo_pwm.sv
// Purpose: servo gate driver; synchronizes the open/close request and moves the pulse width between closed and open.
// Latency: request is seen 2 cycles after it changes, acted on at the next frame boundary; pwm_out lags the frame by 1 cycle.
// Backpressure: none; level request, anything shorter than a frame that misses a boundary is dropped. Macro SERVO_RAMP_EN enables stepped ramps.
module servo_pwm
    import servo_pkg::*;
#(
    parameter  int unsigned FRAME_CYC = FRAME_CYC_DEF,
    parameter  int unsigned PW_CLOSED = PW_CLOSED_DEF,
    parameter  int unsigned PW_OPEN   = PW_OPEN_DEF,
    parameter  int unsigned PW_STEP   = PW_STEP_DEF,
    localparam int unsigned W         = $clog2(FRAME_CYC)
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic mover_servo,
    output logic pwm_out,
    output logic abierta,
    output logic en_movimiento
);

    localparam logic [W-1:0] PW_C = W'(PW_CLOSED);
    localparam logic [W-1:0] PW_O = W'(PW_OPEN);

    // Reject parameter sets that would let pw_cur overshoot or miss an endpoint
    if ((PW_STEP == 0) || !((PW_CLOSED < PW_OPEN) && (PW_OPEN < FRAME_CYC)) ||
        (((PW_OPEN - PW_CLOSED) % PW_STEP) != 0)) begin : g_bad_param
        $error("servo_pwm: invalid timing parameters");
    end

    logic [1:0]   sync_q;
    logic         req_s;
    logic         frame_end;
    servo_state_t state, state_nxt;
    logic [W-1:0] pw_cur, pw_nxt;
    logic [W-1:0] pw_up, pw_dn;

    // Two-flop synchronizer for the scheduler's asynchronous request
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], mover_servo};
        end
    end

    assign req_s = sync_q[1];

`ifdef SERVO_RAMP_EN
    localparam logic [W-1:0] PW_S = W'(PW_STEP);
    // One step toward an endpoint, clamped so pw_cur stays inside [closed, open]
    assign pw_up = (pw_cur >= PW_O - PW_S) ? PW_O : pw_cur + PW_S;
    assign pw_dn = (pw_cur <= PW_C + PW_S) ? PW_C : pw_cur - PW_S;
`else
    // No ramp: the move frame already carries the final pulse width
    assign pw_up = PW_O;
    assign pw_dn = PW_C;
`endif

    // Next state and pulse width, evaluated only on the frame boundary
    always_comb begin
        state_nxt = state;
        pw_nxt    = pw_cur;
        if (frame_end) begin
            case (state)
                CERRADA: begin
                    if (req_s) begin
                        state_nxt = ABRIENDO;
                        pw_nxt    = pw_up;
                    end
                end
                ABRIENDO: begin
                    if (req_s) begin
                        pw_nxt    = pw_up;
                        state_nxt = (pw_up == PW_O) ? ABIERTA : ABRIENDO;
                    end else begin
                        pw_nxt    = pw_dn;
                        state_nxt = CERRANDO;
                    end
                end
                ABIERTA: begin
                    if (!req_s) begin
                        state_nxt = CERRANDO;
                        pw_nxt    = pw_dn;
                    end
                end
                CERRANDO: begin
                    if (!req_s) begin
                        pw_nxt    = pw_dn;
                        state_nxt = (pw_dn == PW_C) ? CERRADA : CERRANDO;
                    end else begin
                        pw_nxt    = pw_up;
                        state_nxt = ABRIENDO;
                    end
                end
                default: begin
                    state_nxt = CERRADA;
                    pw_nxt    = PW_C;
                end
            endcase
        end
    end

    // State and pulse width registers; reset abandons any ramp in progress
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CERRADA;
            pw_cur <= PW_C;
        end else begin
            state  <= state_nxt;
            pw_cur <= pw_nxt;
        end
    end

    assign abierta       = (state == ABIERTA);
    assign en_movimiento = (state == ABRIENDO) || (state == CERRANDO);

    pwm_frame #(
        .FRAME_CYC (FRAME_CYC)
    ) u_frame (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .pw_cur    (pw_cur),
        .frame_end (frame_end),
        .pwm_out   (pwm_out)
    );

endmodule
